// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler driving the DDS frequency word: steps start->stop with clamping and a per-point dwell.
// Define TRIANGLE_SWEEP_EN to make continuous mode sweep out-and-back instead of sawtooth.
module dds_sweep_ctrl #(
    parameter int              FW_W  = 17,
    parameter int              DW_W  = 16,
    parameter logic [FW_W-1:0] F_RST = '0
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            cont,
    input  logic [FW_W-1:0] f_start,
    input  logic [FW_W-1:0] f_stop,
    input  logic [FW_W-1:0] f_step,
    input  logic [DW_W-1:0] dwell,
    output logic [FW_W-1:0] f_word,
    output logic            busy,
    output logic            sweep_done
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    state_t          state_q, state_d;
    logic [FW_W-1:0] f_word_d;
    logic            busy_d, done_d;
    logic [DW_W-1:0] cnt_q, cnt_d;
    logic            capture;

    logic            cont_q, up_q;
    logic [FW_W-1:0] start_q, stop_q, step_q;
    logic [DW_W-1:0] dwell_q;
    logic [FW_W-1:0] step_eff;
    logic [DW_W-1:0] dwell_eff;
    logic [FW_W-1:0] fwd_next;
`ifdef TRIANGLE_SWEEP_EN
    logic            rev_q, rev_d;
    logic [FW_W-1:0] back_next;
`endif

    // One clamped step from cur toward target; the sum is kept one bit wider so it can never wrap.
    function automatic logic [FW_W-1:0] step_toward(
        input logic [FW_W-1:0] cur,
        input logic [FW_W-1:0] target,
        input logic [FW_W-1:0] step,
        input logic            up
    );
        logic [FW_W:0]   sum;
        logic [FW_W-1:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = cur - target;
        if (up)
            step_toward = (sum >= {1'b0, target}) ? target : sum[FW_W-1:0];
        else
            step_toward = (diff <= step) ? target : cur - step;
    endfunction

    assign step_eff  = (f_step == '0) ? FW_W'(1) : f_step;
    assign dwell_eff = (dwell == '0) ? DW_W'(1) : dwell;
    assign capture   = (state_q == IDLE) && start && !stop;
    assign fwd_next  = step_toward(f_word, stop_q, step_q, up_q);
`ifdef TRIANGLE_SWEEP_EN
    assign back_next = step_toward(f_word, start_q, step_q, !up_q);
`endif

    always_comb begin
        state_d  = state_q;
        f_word_d = f_word;
        busy_d   = busy;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
`ifdef TRIANGLE_SWEEP_EN
        rev_d    = rev_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (capture) begin
                    f_word_d = f_start;
                    busy_d   = 1'b1;
                    cnt_d    = dwell_eff;
                    state_d  = DWELL;
`ifdef TRIANGLE_SWEEP_EN
                    rev_d    = 1'b0;
`endif
                end
            end
            DWELL: begin
                if (cnt_q == DW_W'(1)) begin
                    cnt_d = dwell_q;
`ifdef TRIANGLE_SWEEP_EN
                    if (!rev_q && f_word != stop_q) begin
                        f_word_d = fwd_next;
                    end else if (cont_q && back_next != start_q) begin
                        // Return leg skips both endpoints; reaching f_start ends the cycle.
                        f_word_d = back_next;
                        rev_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = cont_q;
                        rev_d   = 1'b0;
                    end
`else
                    if (f_word != stop_q) begin
                        f_word_d = fwd_next;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = cont_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - DW_W'(1);
                end
            end
            DONE: begin
                if (cont_q) begin
                    f_word_d = start_q;
                    cnt_d    = dwell_q;
                    busy_d   = 1'b1;
                    state_d  = DWELL;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort freezes the frequency word where it is and suppresses the done pulse.
        if (stop) begin
            state_d  = IDLE;
            f_word_d = f_word;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            cnt_d    = cnt_q;
`ifdef TRIANGLE_SWEEP_EN
            rev_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            f_word     <= F_RST;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            cnt_q      <= '0;
            cont_q     <= 1'b0;
            up_q       <= 1'b0;
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_q    <= '0;
`ifdef TRIANGLE_SWEEP_EN
            rev_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            f_word     <= f_word_d;
            busy       <= busy_d;
            sweep_done <= done_d;
            cnt_q      <= cnt_d;
`ifdef TRIANGLE_SWEEP_EN
            rev_q      <= rev_d;
`endif
            if (capture) begin
                cont_q  <= cont;
                up_q    <= (f_start <= f_stop);
                start_q <= f_start;
                stop_q  <= f_stop;
                step_q  <= step_eff;
                dwell_q <= dwell_eff;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a point-list reference model feeds an expectation queue,
// and a negedge monitor pops one entry for every cycle the DUT shows busy or sweep_done.
module tb_dds_sweep_ctrl;

    localparam int FW_W = 17;
    localparam int DW_W = 16;
    localparam int FMAX = 'h1FFFF;
`ifdef TRIANGLE_SWEEP_EN
    localparam bit TRI = 1'b1;
`else
    localparam bit TRI = 1'b0;
`endif

    logic            sys_clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            cont = 1'b0;
    logic [FW_W-1:0] f_start = '0;
    logic [FW_W-1:0] f_stop = '0;
    logic [FW_W-1:0] f_step = '0;
    logic [DW_W-1:0] dwell = '0;
    logic [FW_W-1:0] f_word;
    logic            busy;
    logic            sweep_done;

    typedef struct {
        int f;
        bit busy;
        bit done;
    } exp_t;

    exp_t expQ[$];
    exp_t period[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   monOn = 1'b1;
    int   lastF = 0;

    dds_sweep_ctrl #(.FW_W(FW_W), .DW_W(DW_W), .F_RST(17'd0)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop), .cont(cont),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .f_word(f_word), .busy(busy), .sweep_done(sweep_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Monitor: every cycle with sweep activity must match the next queued expectation.
    always @(negedge sys_clk) begin
        exp_t e;
        if (monOn && sys_rst_n && (busy || sweep_done)) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_output: f_word=%0d busy=%0b sweep_done=%0b, required no sweep activity",
                         f_word, busy, sweep_done);
            end else begin
                e = expQ.pop_front();
                if (f_word !== FW_W'(e.f) || busy !== e.busy || sweep_done !== e.done) begin
                    miscompares++;
                    $display("[TB] FAIL sweep_point @%0t: f_word=%0d busy=%0b sweep_done=%0b, required f_word=%0d busy=%0b sweep_done=%0b",
                             $time, f_word, busy, sweep_done, e.f, e.busy, e.done);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int expF, input bit expBusy, input bit expDone);
        vectors++;
        if (f_word !== FW_W'(expF) || busy !== expBusy || sweep_done !== expDone) begin
            miscompares++;
            $display("[TB] FAIL %s: f_word=%0d busy=%0b sweep_done=%0b, required f_word=%0d busy=%0b sweep_done=%0b",
                     name, f_word, busy, sweep_done, expF, expBusy, expDone);
        end
    endtask

    task automatic checkDrained(input string name);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s: %0d expected outputs never appeared, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Reference: list the visited points with plain arithmetic, then expand each by its dwell.
    task automatic buildPeriod(input int fs, input int fe, input int st, input int dw, input bit cm);
        int s, d, p, q;
        int pts[$];
        s = (st == 0) ? 1 : st;
        d = (dw == 0) ? 1 : dw;
        period.delete();
        p = fs;
        pts.push_back(p);
        while (p != fe) begin
            if (fs <= fe) p = (p + s >= fe) ? fe : p + s;
            else          p = (p - fe <= s) ? fe : p - s;
            pts.push_back(p);
        end
        if (TRI && cm && fs != fe) begin
            p = fe;
            forever begin
                if (fs <= fe) q = (p - fs <= s) ? fs : p - s;
                else          q = (p + s >= fs) ? fs : p + s;
                if (q == fs) break;
                pts.push_back(q);
                p = q;
            end
        end
        foreach (pts[i])
            for (int k = 0; k < d; k++) period.push_back('{f: pts[i], busy: 1'b1, done: 1'b0});
        period.push_back('{f: pts[pts.size()-1], busy: cm, done: 1'b1});
    endtask

    // Runs one sweep; continuous sweeps are aborted stopAfter cycles into the second period.
    // Config inputs are scrambled and start re-pulsed while busy; both must be ignored.
    task automatic applyStimulus(input int fs, input int fe, input int st, input int dw,
                                 input bit cm, input int stopAfter);
        int total, mid;
        buildPeriod(fs, fe, st, dw, cm);
        total = cm ? period.size() + stopAfter : period.size();
        for (int i = 0; i < total; i++) expQ.push_back(period[i % period.size()]);
        mid = (total > 2) ? $urandom_range(total - 1, 1) : 0;
        @(posedge sys_clk); #1;
        f_start = FW_W'(fs);
        f_stop  = FW_W'(fe);
        f_step  = FW_W'(st);
        dwell   = DW_W'(dw);
        cont    = cm;
        start   = 1'b1;
        stop    = 1'b0;
        for (int c = 1; c <= total; c++) begin
            @(posedge sys_clk); #1;
            start   = (c == mid);
            f_start = FW_W'($urandom);
            f_stop  = FW_W'($urandom);
            f_step  = FW_W'($urandom);
            dwell   = DW_W'($urandom);
            cont    = 1'($urandom);
            stop    = cm && (c == total);
        end
        @(posedge sys_clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        lastF = period[(total - 1) % period.size()].f;
        checkDrained("drain");
        checkOutput("idle_after_sweep", lastF, 1'b0, 1'b0);
    endtask

    initial begin
        int fs, fe, st, span;
        bit cm;

        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("in_reset", 0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            checkOutput("idle_after_reset", 0, 1'b0, 1'b0);
        end

        $display("[TB] directed sweeps");
        applyStimulus(100, 130, 10, 3, 1'b0, 0);
        applyStimulus(100, 125, 10, 1, 1'b0, 0);
        applyStimulus(50, 20, 20, 1, 1'b0, 0);
        applyStimulus(5, 8, 0, 1, 1'b0, 0);
        applyStimulus(FMAX, FMAX, 7, 2, 1'b0, 0);
        applyStimulus('h1FF00, FMAX, 'h1FFF0, 1, 1'b0, 0);
        applyStimulus('h100, 0, 'h1FFF0, 1, 1'b0, 0);
        applyStimulus(0, 2, 1, 0, 1'b1, 2);
        applyStimulus(0, 2, 1, 1, 1'b1, 7);
        applyStimulus(9, 3, 2, 2, 1'b1, 5);

        // start and stop together in IDLE: nothing may start
        @(posedge sys_clk); #1;
        f_start = 17'd77; f_stop = 17'd99; f_step = 17'd1; dwell = 16'd1; cont = 1'b0;
        start = 1'b1; stop = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0; stop = 1'b0;
        @(posedge sys_clk); #1;
        checkOutput("start_with_stop", lastF, 1'b0, 1'b0);

        // reset in the middle of a sweep
        monOn = 1'b0;
        @(posedge sys_clk); #1;
        f_start = 17'd100; f_stop = 17'd130; f_step = 17'd10; dwell = 16'd3; cont = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk); #1;
            start = 1'b0;
        end
        checkOutput("mid_sweep", 110, 1'b1, 1'b0);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        checkOutput("reset_mid_sweep", 0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        checkOutput("idle_after_mid_reset", 0, 1'b0, 1'b0);
        monOn = 1'b1;

        $display("[TB] random sweeps");
        for (int n = 0; n < 24; n++) begin
            fs   = $urandom_range(FMAX, 0);
            span = $urandom_range(100, 0);
            if ($urandom_range(1, 0) == 1) fe = (fs + span > FMAX) ? FMAX : fs + span;
            else                           fe = (fs - span < 0) ? 0 : fs - span;
            st = ($urandom_range(7, 0) == 0) ? $urandom_range(FMAX, 0) : $urandom_range(30, 0);
            cm = 1'($urandom_range(1, 0));
            applyStimulus(fs, fe, st, $urandom_range(3, 0), cm, $urandom_range(40, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
